lion_gate_driver: RTL and testbench

LION_GATE_DRIVER -- requirements
Module: lion_gate_driver

---
 rtl/lion_gate_driver.sv | 99 +++++++++
 tb/tb_lion_gate_driver.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lion_gate_driver.sv
// Light-gate pattern transmitter: emits entry/exit passages on two emulated beams
// and keeps the count a downstream two-gate cage counter should be holding.
//
// state | meaning
// IDLE  | ready for a command, beams dark (00)
// P1    | first beam interrupted (entry 10, exit 01)
// P2    | both beams interrupted (11)
// P3    | second beam interrupted (entry 01, exit 10)
// GAP   | beams clear (00) before returning to IDLE
module lion_gate_driver #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic             cmd_dir,
    input  logic [7:0]       dwell,
    output logic             cmd_ready,
    output logic             g_one,
    output logic             g_two,
    output logic             done,
    output logic [CNT_W-1:0] shadow_count
);

    typedef enum logic [2:0] {IDLE, P1, P2, P3, GAP} state_t;

    state_t     state;
    logic       dir_q;
    logic [7:0] reload;
    logic [7:0] phase_cnt;
    logic [7:0] dwell_m1;

    // A dwell of 0 behaves like 1; the counter holds cycles remaining minus one.
    assign dwell_m1  = (dwell == 8'd0) ? 8'd0 : dwell - 8'd1;
    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dir_q        <= 1'b0;
            reload       <= 8'd0;
            phase_cnt    <= 8'd0;
            g_one        <= 1'b0;
            g_two        <= 1'b0;
            done         <= 1'b0;
            shadow_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= P1;
                        dir_q     <= cmd_dir;
                        reload    <= dwell_m1;
                        phase_cnt <= dwell_m1;
                        g_one     <= cmd_dir;
                        g_two     <= ~cmd_dir;
                        if (cmd_dir)
                            shadow_count <= shadow_count + CNT_W'(1);
                    end
                end
                P1, P2, P3, GAP: begin
                    if (phase_cnt != 8'd0) begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end else begin
                        phase_cnt <= reload;
                        case (state)
                            P1: begin
                                state <= P2;
                                g_one <= 1'b1;
                                g_two <= 1'b1;
                            end
                            P2: begin
                                state <= P3;
                                g_one <= ~dir_q;
                                g_two <= dir_q;
                            end
                            P3: begin
                                // Exit is counted where g_one falls with g_two already clear.
                                state <= GAP;
                                g_one <= 1'b0;
                                g_two <= 1'b0;
                                if (!dir_q)
                                    shadow_count <= shadow_count - CNT_W'(1);
                            end
                            default: begin
                                state     <= IDLE;
                                phase_cnt <= 8'd0;
                                done      <= 1'b1;
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lion_gate_driver.sv
// Directed bench for lion_gate_driver: phase codes, timing, wrap, back-to-back,
// mid-event reset and a closed loop against a two-gate cage counter model.
module tb_lion_gate_driver;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_dir;
    logic [7:0] dwell;
    logic       cmd_ready;
    logic       g_one;
    logic       g_two;
    logic       done;
    logic [3:0] shadow_count;

    int n_checks;
    int n_errors;
    logic [3:0] exp_shadow;
    logic [3:0] gate_cnt;
    logic       prev_g1;

    lion_gate_driver #(.CNT_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_dir      (cmd_dir),
        .dwell        (dwell),
        .cmd_ready    (cmd_ready),
        .g_one        (g_one),
        .g_two        (g_two),
        .done         (done),
        .shadow_count (shadow_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream counter: +1 on g_one rise with g_two=0, -1 on g_one fall with g_two=0.
    always @(negedge clk) begin
        if (reset) begin
            gate_cnt <= 4'd0;
            prev_g1  <= 1'b0;
        end else begin
            if (g_one && !prev_g1 && !g_two)
                gate_cnt <= gate_cnt + 4'd1;
            else if (!g_one && prev_g1 && !g_two)
                gate_cnt <= gate_cnt - 4'd1;
            prev_g1 <= g_one;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        exp_shadow = 4'd0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic run_event(input logic dir, input logic [7:0] dw);
        int d;
        logic [1:0] codes [4];
        d = (dw == 8'd0) ? 1 : int'(dw);
        if (dir) codes = '{2'b10, 2'b11, 2'b01, 2'b00};
        else     codes = '{2'b01, 2'b11, 2'b10, 2'b00};
        chk("ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        dwell     = dw;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_dir   = ~dir;
        dwell     = 8'd200 - dw;
        if (dir) exp_shadow = exp_shadow + 4'd1;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < d; c++) begin
                if (!dir && p == 3 && c == 0) exp_shadow = exp_shadow - 4'd1;
                chk("gates", {g_one, g_two}, codes[p]);
                chk("busy", cmd_ready, 0);
                chk("done_low", done, 0);
                chk("shadow", shadow_count, exp_shadow);
                @(negedge clk);
            end
        end
        chk("done_pulse", done, 1);
        chk("ready_post", cmd_ready, 1);
        chk("gates_idle", {g_one, g_two}, 0);
    endtask

    initial begin
        int last;
        int accepts;
        logic was_accept;
        logic [7:0] rd;
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        dwell      = 8'd0;
        exp_shadow = 4'd0;

        do_reset();
        chk("rst_ready", cmd_ready, 1);
        chk("rst_gates", {g_one, g_two}, 0);
        chk("rst_done", done, 0);
        chk("rst_shadow", shadow_count, 0);

        run_event(1'b1, 8'd3);
        run_event(1'b0, 8'd0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        // Underflow then 16 entries wrap back to 15.
        run_event(1'b0, 8'd1);
        chk("wrap_under", shadow_count, 4'd15);
        for (int i = 0; i < 16; i++)
            run_event(1'b1, (i % 2 == 0) ? 8'd1 : 8'd0);
        chk("wrap_16", shadow_count, 4'd15);

        // Held cmd_valid, alternating direction, dwell 2.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        dwell     = 8'd2;
        last      = -1;
        accepts   = 0;
        for (int cyc = 0; cyc < 37; cyc++) begin
            was_accept = cmd_ready;
            if (cmd_ready) begin
                if (accepts > 0) chk("b2b_gap", cyc - last, 9);
                last = cyc;
                accepts++;
            end else begin
                chk("b2b_busy", (cyc - last >= 1) && (cyc - last <= 8), 1);
            end
            @(posedge clk);
            @(negedge clk);
            if (was_accept) cmd_dir = ~cmd_dir;
        end
        cmd_valid = 1'b0;
        chk("b2b_accepts", accepts, 5);
        chk("b2b_shadow", shadow_count, 4'd0);
        begin
            int k;
            k = 0;
            while (!done && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("b2b_drain", done, 1);
        end
        @(negedge clk);
        exp_shadow = 4'd0;

        // Reset in P2 of an entry.
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        dwell     = 8'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_p2", {g_one, g_two}, 2'b11);
        chk("mid_shadow", shadow_count, 4'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_gates", {g_one, g_two}, 0);
        chk("mid_rst_shadow", shadow_count, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        reset = 1'b0;
        exp_shadow = 4'd0;
        for (int i = 0; i < 16; i++) begin
            chk("mid_no_done", done, 0);
            chk("mid_quiet", {g_one, g_two}, 0);
            @(negedge clk);
        end
        run_event(1'b1, 8'd2);

        // Closed loop: 5 entries, 2 exits, random dwell 1..8.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            rd = 8'($urandom_range(1, 8));
            run_event((i == 2 || i == 5) ? 1'b0 : 1'b1, rd);
        end
        repeat (2) @(negedge clk);
        chk("loop_counter", gate_cnt, shadow_count);
        chk("loop_shadow", shadow_count, 4'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
